alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised, handshaked successor of the datapath ALU. Registers every result; adds shifts and
//  an optional iterative multiply. Sits between operand fetch and writeback; both sides use valid/ready.
//  Flags (zero/neg/carry/ovf) are registered alongside the result.
// PARAMETERS
//  DATA_W   64  operand/result width; power of two, >= 8
//  SH_W     $clog2(DATA_W)  shift-amount width, derived (localparam)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  in_valid   in   1       operands/opcode valid
//  in_ready   out  1       block can accept this cycle
//  aluOP      in   3       000 ADD, 001 SUB, 010 AND, 011 ORR, 100 PASSB, 101 SLL, 110 SRL, 111 MUL
//  A          in   DATA_W  operand A
//  B          in   DATA_W  operand B (shift amount = B[SH_W-1:0])
//  out_valid  out  1       result valid
//  out_ready  in   1       consumer accepts result
//  bus_resultOP out DATA_W registered result
//  zero       out  1       bus_resultOP == 0
//  neg        out  1       bus_resultOP[DATA_W-1]
//  carry      out  1       ADD carry-out / SUB no-borrow (A>=B unsigned); 0 for other ops
//  ovf        out  1       signed overflow for ADD/SUB; 0 for other ops
//  illegal    out  1       MUL requested while ALU_SEQ_MUL_EN undefined
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, out_valid=0, bus_resultOP=0, zero=1, neg/carry/ovf/illegal=0.
//  - FSM IDLE -> (accept, op!=MUL) -> DONE; IDLE -> (accept MUL) -> BUSY; BUSY -> (count==DATA_W-1) -> DONE;
//    DONE -> (out_ready & !accept) -> IDLE; DONE -> (out_ready & accept) -> DONE/BUSY per new op.
//  - in_ready = (state==IDLE) | (state==DONE & out_ready); 0 in BUSY. Accept = in_valid & in_ready.
//  - Non-MUL ops: result+flags registered on the accepting edge; out_valid high the following cycle.
//    Back-to-back throughput 1 op/cycle when out_ready held high.
//  - MUL: shift-add, one bit/cycle, DATA_W cycles in BUSY; out_valid high after accept edge + DATA_W edges.
//    Result = low DATA_W bits of unsigned A*B; carry/ovf=0. Operands latched at accept; A/B may change after.
//  - PASSB: result = (B==0) ? 0 : all-ones (full DATA_W, not 32-bit).
//  - SLL/SRL: logical; shift amount 0 returns A unchanged.
//  - out_valid & !out_ready: result, flags, out_valid held stable (no overwrite, in_ready=0).
//  - ADD/SUB wrap modulo 2^DATA_W; carry = bit DATA_W of extended op, SUB computed as A+~B+1.
//  - No latches: every opcode has a defined result; no default-case holdover.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined: MUL as above, alu_seq_mul instantiated.
//  ALU_SEQ_MUL_EN undefined: MUL completes like a 1-cycle op, result=0, zero=1, illegal=1 (illegal=0 all else);
//    BUSY state unreachable; no multiplier logic synthesised.
// STRUCTURE
//  alu_seq_pkg: opcode localparams (OP_ADD..OP_MUL), FSM state encoding (ST_IDLE/ST_BUSY/ST_DONE).
//  Sub-module alu_seq_mul: start/busy/done iterative multiplier, DATA_W-parametrised, owns counter and
//  partial-product/multiplier shift registers. Top owns FSM, handshake, combinational op mux, flag regs.
// TESTING
//  1 Reset mid-MUL (assert rst at BUSY cycle 5) -> out_valid=0, in_ready=1, bus_resultOP=0, zero=1 next cycle.
//  2 ADD A=64'hFFFF_FFFF_FFFF_FFFF B=1 -> result 0, zero=1, carry=1, ovf=0; ADD 7FFF..F+1 -> 8000..0, neg=1, ovf=1.
//  3 SUB A=3 B=5 -> FFFF..FE, carry=0, neg=1; PASSB B=0 -> 0; PASSB B=1 -> all-ones 64 bits.
//  4 SLL A=1 B=63 -> 8000..0; SRL A=8000..0 B=64'h43 (amount 3) -> 1000..0; shift amount 0 -> A.
//  5 Backpressure: 3 ADDs streamed, out_ready low 4 cycles on 2nd -> result held stable, in_ready=0, no loss/reorder.
//  6 MUL A=12345 B=6789 (MUL_EN) -> 83810205 after exactly 64 edges, in_ready=0 throughout BUSY;
//    without MUL_EN -> 1-cycle, result 0, illegal=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode encodings and FSM state type for the alu_seq datapath.
package alu_seq_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_AND   = 3'b010;
    localparam logic [2:0] OP_ORR   = 3'b011;
    localparam logic [2:0] OP_PASSB = 3'b100;
    localparam logic [2:0] OP_SLL   = 3'b101;
    localparam logic [2:0] OP_SRL   = 3'b110;
    localparam logic [2:0] OP_MUL   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, DATA_W cycles after start.
// Produces the low DATA_W bits of the unsigned product.
module alu_seq_mul #(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  count;
    logic              running;

    // product is the accumulator after the current step, so the final sum is
    // available on the same edge that done is seen by the consumer.
    assign product = acc + (mplier[0] ? mcand : '0);
    assign busy    = running;
    assign done    = running && (count == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            mcand   <= a;
            mplier  <= b;
            acc     <= '0;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc     <= product;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            count   <= count + CNT_W'(1);
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked, registered ALU with flags. Define ALU_SEQ_MUL_EN to build the iterative
// multiplier; without it MUL completes in one cycle with result 0 and illegal=1.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        aluOP,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] bus_resultOP,
    output logic              zero,
    output logic              neg,
    output logic              carry,
    output logic              ovf,
    output logic              illegal
);

    localparam int unsigned SH_W = $clog2(DATA_W);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              is_mul;
    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    logic [DATA_W-1:0] res_c;
    logic              carry_c;
    logic              ovf_c;
    logic              illegal_c;
    logic [DATA_W-1:0] b_add;
    logic [DATA_W:0]   sum_ext;
    logic [SH_W-1:0]   sh;

`ifdef ALU_SEQ_MUL_EN
    logic mul_start;

    assign is_mul    = (aluOP == OP_MUL);
    assign mul_start = accept && is_mul;

    alu_seq_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign is_mul      = 1'b0;
    assign mul_busy    = 1'b0;
    assign mul_done    = 1'b0;
    assign mul_product = '0;
`endif

    assign in_ready  = ((state == ST_IDLE) || ((state == ST_DONE) && out_ready)) && !mul_busy;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == ST_DONE);

    always_comb begin
        b_add     = (aluOP == OP_SUB) ? ~B : B;
        sum_ext   = {1'b0, A} + {1'b0, b_add} + {{DATA_W{1'b0}}, (aluOP == OP_SUB)};
        sh        = B[SH_W-1:0];
        res_c     = '0;
        carry_c   = 1'b0;
        ovf_c     = 1'b0;
        illegal_c = 1'b0;
        case (aluOP)
            OP_ADD, OP_SUB: begin
                res_c   = sum_ext[DATA_W-1:0];
                carry_c = sum_ext[DATA_W];
                ovf_c   = (A[DATA_W-1] == b_add[DATA_W-1]) && (res_c[DATA_W-1] != A[DATA_W-1]);
            end
            OP_AND:   res_c = A & B;
            OP_ORR:   res_c = A | B;
            OP_PASSB: res_c = (B == '0) ? '0 : '1;
            OP_SLL:   res_c = A << sh;
            OP_SRL:   res_c = A >> sh;
            OP_MUL: begin
                res_c = '0;
`ifndef ALU_SEQ_MUL_EN
                illegal_c = 1'b1;
`endif
            end
            default:  res_c = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = is_mul ? ST_BUSY : ST_DONE;
            ST_BUSY: if (mul_done) state_next = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    if (accept) state_next = is_mul ? ST_BUSY : ST_DONE;
                    else        state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_resultOP <= '0;
            zero         <= 1'b1;
            neg          <= 1'b0;
            carry        <= 1'b0;
            ovf          <= 1'b0;
            illegal      <= 1'b0;
        end else if (accept && !is_mul) begin
            bus_resultOP <= res_c;
            zero         <= (res_c == '0);
            neg          <= res_c[DATA_W-1];
            carry        <= carry_c;
            ovf          <= ovf_c;
            illegal      <= illegal_c;
        end else if ((state == ST_BUSY) && mul_done) begin
            bus_resultOP <= mul_product;
            zero         <= (mul_product == '0);
            neg          <= mul_product[DATA_W-1];
            carry        <= 1'b0;
            ovf          <= 1'b0;
            illegal      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq; follows ALU_SEQ_MUL_EN for the MUL expectations.
module tb_alu_seq;
    import alu_seq_pkg::*;

    localparam int unsigned W = 64;
    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] MSB  = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [2:0]   aluOP = OP_ADD;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] bus_resultOP;
    logic         zero, neg, carry, ovf, illegal;
    logic [4:0]   flags;

    int n_checks = 0;
    int n_errors = 0;

    assign flags = {zero, neg, carry, ovf, illegal};

    alu_seq #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .aluOP        (aluOP),
        .A            (A),
        .B            (B),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .bus_resultOP (bus_resultOP),
        .zero         (zero),
        .neg          (neg),
        .carry        (carry),
        .ovf          (ovf),
        .illegal      (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge where out_valid rose.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] er, input logic [4:0] ef,
                          input int el);
        int  n;
        logic rdy_in_busy;
        in_valid = 1'b1;
        aluOP    = op;
        A        = a;
        B        = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        A = ~a;
        B = ~b;
        n = 0;
        rdy_in_busy = 1'b0;
        while (!out_valid && n < 200) begin
            rdy_in_busy |= in_ready;
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, n, el);
        if (el > 0) check({tag, "_busy_ready"}, rdy_in_busy, 0);
        check({tag, "_res"}, bus_resultOP, er);
        check({tag, "_flags"}, flags, ef);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_res", bus_resultOP, 0);
        check("rst_flags", flags, 5'b10000);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // flags packed as {zero, neg, carry, ovf, illegal}
        run_op("add_wrap",   OP_ADD,   ONES, 64'd1, 64'd0, 5'b10100, 0);
        run_op("add_ovf",    OP_ADD,   ~MSB, 64'd1, MSB, 5'b01010, 0);
        run_op("sub_borrow", OP_SUB,   64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 5'b01000, 0);
        run_op("sub_pos",    OP_SUB,   64'd5, 64'd3, 64'd2, 5'b00100, 0);
        run_op("sub_ovf",    OP_SUB,   MSB, 64'd1, ~MSB, 5'b00110, 0);
        run_op("and",        OP_AND,   64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
               64'hF000_F000_F000_F000, 5'b01000, 0);
        run_op("orr",        OP_ORR,   64'h0F, 64'hF0, 64'hFF, 5'b00000, 0);
        run_op("passb_0",    OP_PASSB, 64'd5, 64'd0, 64'd0, 5'b10000, 0);
        run_op("passb_1",    OP_PASSB, 64'd0, 64'd1, ONES, 5'b01000, 0);
        run_op("passb_hi",   OP_PASSB, 64'd0, 64'h1_0000_0000, ONES, 5'b01000, 0);
        run_op("sll_63",     OP_SLL,   64'd1, 64'd63, MSB, 5'b01000, 0);
        run_op("srl_3",      OP_SRL,   MSB, 64'h43, 64'h1000_0000_0000_0000, 5'b00000, 0);
        run_op("sll_0",      OP_SLL,   64'h1234, 64'd0, 64'h1234, 5'b00000, 0);
        run_op("srl_0",      OP_SRL,   64'h1234, 64'h40, 64'h1234, 5'b00000, 0);
        run_op("sll_4",      OP_SLL,   64'h3, 64'd4, 64'h30, 5'b00000, 0);
        run_op("srl_60",     OP_SRL,   ONES, 64'd60, 64'hF, 5'b00000, 0);

`ifdef ALU_SEQ_MUL_EN
        run_op("mul",        OP_MUL,   64'd12345, 64'd6789, 64'd83810205, 5'b00000, 64);
        run_op("mul_ones",   OP_MUL,   ONES, ONES, 64'd1, 5'b00000, 64);
        run_op("mul_trunc",  OP_MUL,   64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 5'b10000, 64);
`else
        run_op("mul_illegal", OP_MUL,  64'd12345, 64'd6789, 64'd0, 5'b10001, 0);
`endif
        run_op("after_mul",  OP_ADD,   64'd40, 64'd2, 64'd42, 5'b00000, 0);

        // Backpressure: three streamed ADDs, consumer stalls on the second.
        in_valid  = 1'b1;
        aluOP     = OP_ADD;
        A         = 64'd10;
        B         = 64'd1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_r1", bus_resultOP, 64'd11);
        A = 64'd20;
        B = 64'd2;
        @(posedge clk); #1;
        check("bp_r2", bus_resultOP, 64'd22);
        out_ready = 1'b0;
        A = 64'd30;
        B = 64'd3;
        for (int unsigned i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("bp_hold_res", bus_resultOP, 64'd22);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_r3", bus_resultOP, 64'd33);
        check("bp_r3_valid", out_valid, 1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_drain", out_valid, 0);
        check("bp_drain_res", bus_resultOP, 64'd33);

        // Asynchronous reset while work is in flight.
        in_valid = 1'b1;
`ifdef ALU_SEQ_MUL_EN
        aluOP = OP_MUL;
        A     = 64'd12345;
        B     = 64'd6789;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_mid_busy_ready", in_ready, 0);
`else
        aluOP     = OP_ADD;
        A         = 64'd5;
        B         = 64'd5;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rst_mid_res_before", bus_resultOP, 64'd10);
        @(posedge clk); #1;
`endif
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_in_ready", in_ready, 1);
        check("rst_mid_res", bus_resultOP, 0);
        check("rst_mid_flags", flags, 5'b10000);
        @(negedge clk) rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", OP_ADD, 64'd2, 64'd3, 64'd5, 5'b00000, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
